// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer feeding the size handler: reads the memory word,
// then returns the handler result as load data or writes it back (RMW for SB/SH).
module mem_access_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  hdl_sel,
  output logic [31:0] hdl_mem,
  input  logic [31:0] hdl_out,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, FINISH} state_t;

  localparam logic [2:0] OP_SB = 3'd0;
  localparam logic [2:0] OP_SW = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_LB = 3'd3;
  localparam logic [2:0] OP_LW = 3'd4;
  localparam logic [2:0] OP_LH = 3'd5;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [2:0]  cnt;
  logic        err_q;
  logic        req_bad;
  logic        op_is_load;

  // Request screening uses the raw inputs since it is only consulted in IDLE.
  always_comb begin
    req_bad = 1'b0;
    case (op)
      OP_SW, OP_LW: req_bad = (addr[1:0] != 2'b00);
      OP_SH, OP_LH: req_bad = addr[0];
      OP_SB, OP_LB: req_bad = 1'b0;
      default:      req_bad = 1'b1;
    endcase
  end

  assign op_is_load = (op_q == OP_LB) || (op_q == OP_LW) || (op_q == OP_LH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    mem_addr  = 32'd0;
    mem_wr    = 1'b0;
    mem_wdata = 32'd0;
    hdl_sel   = op_q;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        hdl_sel = 3'b000;
        if (start) begin
          if (req_bad)          state_nx = FINISH;
          else if (op == OP_SW) state_nx = WRITE;
          else                  state_nx = READ;
        end
      end
      READ: begin
        mem_addr = addr_q;
        if (cnt == 3'd0) state_nx = LATCH;
      end
      LATCH: begin
        mem_addr = addr_q;
        state_nx = op_is_load ? FINISH : WRITE;
      end
      WRITE: begin
        mem_addr  = addr_q;
        mem_wr    = 1'b1;
        mem_wdata = hdl_out;
        state_nx  = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // hdl_mem is loaded on the last READ edge so hdl_out has settled through LATCH,
  // which lets load_data sample it on the FINISH entry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 3'b000;
      addr_q    <= 32'd0;
      cnt       <= 3'd0;
      err_q     <= 1'b0;
      hdl_mem   <= 32'd0;
      load_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            addr_q <= {addr[31:2], 2'b00};
            err_q  <= req_bad;
            cnt    <= LAT_INIT;
          end
        end
        READ: begin
          if (cnt == 3'd0) hdl_mem <= mem_rdata;
          else             cnt     <= cnt - 3'd1;
        end
        LATCH: begin
          if (op_is_load) load_data <= hdl_out;
        end
        default: ;
      endcase
    end
  end

endmodule
